elevator_ctrl: RTL

Car-motion controller for the elevator experiment. It latches floor requests from debounced buttons and runs a SCAN (collective) state machine that moves the car one floor per slow tick. It holds the door open for a fixed number of ticks and drives floor/direction/door status to the display logic. It sits directly downstream of the clock divider, consuming its slow rate as a single-cycle tick enable in the system clock domain rather than as a derived clock.

---
 rtl/elevator_pkg.sv | 19 +
 rtl/elevator_ctrl_req_scan.sv | 32 +++
 rtl/elevator_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the elevator car controller.
//   state_t        : controller state encoding
//   N_FLOORS_DEF   : default number of floors
//   DOOR_TICKS_DEF : default door-open time in travel ticks
//   DCNT_W         : door counter width (holds up to 15 ticks)
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE_UP = 2'd1,
    MOVE_DN = 2'd2,
    DOOR    = 2'd3
  } state_t;

  localparam int unsigned N_FLOORS_DEF   = 4;
  localparam int unsigned DOOR_TICKS_DEF = 2;
  localparam int unsigned DCNT_W         = 4;

endpackage

// File: rtl/elevator_ctrl_req_scan.sv
// Combinational request scan: summarizes pending requests relative to the car.
//   i_pending   : latched request bits, one per floor
//   i_cur_floor : current car floor
//   o_above_c   : some request strictly above the car
//   o_below_c   : some request strictly below the car
//   o_here_c    : request at the car's floor
module req_scan
  import elevator_pkg::*;
#(
  parameter int unsigned N_FLOORS = N_FLOORS_DEF,
  parameter int unsigned FW       = $clog2(N_FLOORS)
) (
  input  logic [N_FLOORS-1:0] i_pending,
  input  logic [FW-1:0]       i_cur_floor,
  output logic                o_above_c,
  output logic                o_below_c,
  output logic                o_here_c
);

  // Compare each floor index against the car position.
  always_comb begin
    o_above_c = 1'b0;
    o_below_c = 1'b0;
    o_here_c  = 1'b0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (i > 32'(i_cur_floor))  o_above_c = o_above_c | i_pending[i];
      if (i < 32'(i_cur_floor))  o_below_c = o_below_c | i_pending[i];
      if (i == 32'(i_cur_floor)) o_here_c  = o_here_c  | i_pending[i];
    end
  end

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN elevator car controller driven by a slow travel tick enable.
//   clk_in    : system clock
//   rst       : asynchronous active-high reset
//   tick      : one-cycle travel-rate strobe
//   req_in    : one-cycle floor request pulses
//   cur_floor : current car floor
//   dir_up    : last/current travel direction is up
//   moving    : car travelling
//   door_open : door open at cur_floor
//   pending   : latched, unserved requests
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned N_FLOORS   = N_FLOORS_DEF,
  parameter int unsigned FW         = $clog2(N_FLOORS),
  parameter int unsigned DOOR_TICKS = DOOR_TICKS_DEF
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                tick,
  input  logic [N_FLOORS-1:0] req_in,
  output logic [FW-1:0]       cur_floor,
  output logic                dir_up,
  output logic                moving,
  output logic                door_open,
  output logic [N_FLOORS-1:0] pending
);

  localparam logic [FW-1:0]     TOP_FLOOR = FW'(N_FLOORS - 1);
  localparam logic [DCNT_W-1:0] DOOR_LOAD = DCNT_W'(DOOR_TICKS);

  state_t              r_state;
  logic [FW-1:0]       r_cur_floor;
  logic                r_dir_up;
  logic                r_moving;
  logic                r_door_open;
  logic [N_FLOORS-1:0] r_pending;
  logic [DCNT_W-1:0]   r_door_cnt;

  state_t              w_next_state;
  logic [FW-1:0]       w_next_floor;
  logic                w_next_dir;
  logic [N_FLOORS-1:0] w_next_pending;
  logic [N_FLOORS-1:0] w_clr;
  logic [DCNT_W-1:0]   w_next_cnt;
  logic                w_above;
  logic                w_below;
  logic                w_here;
  logic                w_req_here;
  logic                w_pend_up;
  logic                w_pend_dn;
  logic                w_at_top;
  logic                w_at_bot;
  logic                w_door_done;
  logic [FW-1:0]       w_floor_up;
  logic [FW-1:0]       w_floor_dn;

  req_scan #(
    .N_FLOORS (N_FLOORS),
    .FW       (FW)
  ) u_req_scan (
    .i_pending   (r_pending),
    .i_cur_floor (r_cur_floor),
    .o_above_c   (w_above),
    .o_below_c   (w_below),
    .o_here_c    (w_here)
  );

  assign w_at_top    = (r_cur_floor == TOP_FLOOR);
  assign w_at_bot    = (r_cur_floor == '0);
  assign w_floor_up  = r_cur_floor + FW'(1);
  assign w_floor_dn  = r_cur_floor - FW'(1);
  // Re-open requests take precedence over the closing tick.
  assign w_door_done = !w_req_here && tick && (r_door_cnt == DCNT_W'(1));

  // Neighbouring-floor request bits and a live request at the car's floor.
  always_comb begin
    w_pend_up  = 1'b0;
    w_pend_dn  = 1'b0;
    w_req_here = 1'b0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (i == 32'(r_cur_floor) + 32'd1) w_pend_up  = r_pending[i];
      if (i + 32'd1 == 32'(r_cur_floor)) w_pend_dn  = r_pending[i];
      if (i == 32'(r_cur_floor))         w_req_here = req_in[i];
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cur_floor <= '0;
      r_dir_up    <= 1'b1;
      r_moving    <= 1'b0;
      r_door_open <= 1'b0;
      r_pending   <= '0;
      r_door_cnt  <= '0;
    end else begin
      r_state     <= w_next_state;
      r_cur_floor <= w_next_floor;
      r_dir_up    <= w_next_dir;
      r_moving    <= (w_next_state == MOVE_UP) || (w_next_state == MOVE_DN);
      r_door_open <= (w_next_state == DOOR);
      r_pending   <= w_next_pending;
      r_door_cnt  <= w_next_cnt;
    end
  end

  // Next-state selection: SCAN keeps the current direction while it has work.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_here)       w_next_state = DOOR;
        else if (w_above) w_next_state = MOVE_UP;
        else if (w_below) w_next_state = MOVE_DN;
      end
      MOVE_UP: begin
        if (tick) begin
          if (w_at_top)       w_next_state = IDLE;
          else if (w_pend_up) w_next_state = DOOR;
        end
      end
      MOVE_DN: begin
        if (tick) begin
          if (w_at_bot)       w_next_state = IDLE;
          else if (w_pend_dn) w_next_state = DOOR;
        end
      end
      DOOR: begin
        if (w_door_done) begin
          if (r_dir_up ? w_above : w_below)
            w_next_state = r_dir_up ? MOVE_UP : MOVE_DN;
          else if (r_dir_up ? w_below : w_above)
            w_next_state = r_dir_up ? MOVE_DN : MOVE_UP;
          else
            w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath next values: floor step, direction, door timer, request latch.
  always_comb begin
    w_next_floor = r_cur_floor;
    w_next_dir   = r_dir_up;
    w_next_cnt   = r_door_cnt;
    w_clr        = '0;

    if (tick && (r_state == MOVE_UP) && !w_at_top) w_next_floor = w_floor_up;
    if (tick && (r_state == MOVE_DN) && !w_at_bot) w_next_floor = w_floor_dn;

    if (w_next_state == MOVE_UP) w_next_dir = 1'b1;
    if (w_next_state == MOVE_DN) w_next_dir = 1'b0;

    if (w_next_state == DOOR && r_state != DOOR) begin
      w_next_cnt = DOOR_LOAD;
    end else if (r_state == DOOR) begin
      if (w_req_here)                        w_next_cnt = DOOR_LOAD;
      else if (tick && r_door_cnt != '0)     w_next_cnt = r_door_cnt - DCNT_W'(1);
    end

    // The floor being served never holds a request bit.
    if (w_next_state == DOOR) begin
      for (int unsigned i = 0; i < N_FLOORS; i++) begin
        w_clr[i] = (i == 32'(w_next_floor));
      end
    end
    w_next_pending = (r_pending | req_in) & ~w_clr;
  end

  assign cur_floor = r_cur_floor;
  assign dir_up    = r_dir_up;
  assign moving    = r_moving;
  assign door_open = r_door_open;
  assign pending   = r_pending;

endmodule
